seg7_scan_ctrl: RTL and testbench

Sequencing controller that converts an NDIG-digit hex value into per-digit 7-segment patterns using one shared hex-to-segment decode, time-multiplexed across digit positions. It sits between the file-reader/status logic, which produces hex values, and the board's HEX display pins. A load strobe starts a scan, busy and done report progress, and a load that arrives mid-scan is queued as pending.

---
 rtl/seg7_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed hex-to-7-segment scan controller.
// One shared decoder walks the latched value MSB digit first, one digit per
// cycle, into a registered active-low segment bank. A load that arrives
// mid-scan is parked in a one-deep pending slot (last load wins).
// Optional: define SEG7_SCAN_LZBLANK_EN to blank leading zeros (digit 0 is
// always shown).
module seg7_scan_ctrl #(
  parameter int NDIG = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [4*NDIG-1:0] value,
  output logic              busy,
  output logic              done,
  output logic [7*NDIG-1:0] seg
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [NDIG-1:0][3:0]      val_q, val_d;
  logic [NDIG-1:0][3:0]      pend_q, pend_d;
  logic                      pv_q, pv_d;
  logic [NDIG-1:0][6:0]      seg_q, seg_d;
  logic [NDIG-1:0][3:0]      value_a;
  logic [3:0]                cur_dig;
  logic [6:0]                cur_seg;
`ifdef SEG7_SCAN_LZBLANK_EN
  logic                      nz_q, nz_d;
`endif

  assign value_a = value;
  assign cur_dig = val_q[idx_q];
  assign busy    = (state_q == SCAN);
  assign done    = (state_q == DONE);
  assign seg     = seg_q;

  // Shared active-low hex decoder, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    cur_seg = 7'b1111111;
    case (cur_dig)
      4'h0: cur_seg = 7'b1000000;
      4'h1: cur_seg = 7'b1111001;
      4'h2: cur_seg = 7'b0100100;
      4'h3: cur_seg = 7'b0110000;
      4'h4: cur_seg = 7'b0011001;
      4'h5: cur_seg = 7'b0010010;
      4'h6: cur_seg = 7'b0000010;
      4'h7: cur_seg = 7'b1111000;
      4'h8: cur_seg = 7'b0000000;
      4'h9: cur_seg = 7'b0011000;
      4'hA: cur_seg = 7'b0001000;
      4'hB: cur_seg = 7'b0000011;
      4'hC: cur_seg = 7'b1000110;
      4'hD: cur_seg = 7'b0100001;
      4'hE: cur_seg = 7'b0000110;
      4'hF: cur_seg = 7'b0001110;
      default: cur_seg = 7'b1111111;
    endcase
  end

  // Next-state: scan sequencing, pending-load capture and digit writes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    val_d   = val_q;
    pend_d  = pend_q;
    pv_d    = pv_q;
    seg_d   = seg_q;
`ifdef SEG7_SCAN_LZBLANK_EN
    nz_d    = nz_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          val_d   = value_a;
          idx_d   = IDX_TOP;
          state_d = SCAN;
`ifdef SEG7_SCAN_LZBLANK_EN
          nz_d    = 1'b0;
`endif
        end
      end
      SCAN: begin
`ifdef SEG7_SCAN_LZBLANK_EN
        // Leading zeros blank until the first nonzero digit; digit 0 always shows.
        if (cur_dig == 4'h0 && !nz_q && idx_q != '0) seg_d[idx_q] = 7'b1111111;
        else                                         seg_d[idx_q] = cur_seg;
        nz_d = nz_q | (cur_dig != 4'h0);
`else
        seg_d[idx_q] = cur_seg;
`endif
        if (idx_q == '0) state_d = DONE;
        else             idx_d   = idx_q - IW'(1);
        if (load) begin
          pend_d = value_a;
          pv_d   = 1'b1;
        end
      end
      DONE: begin
        // A fresh load beats the parked one; otherwise drain pending, else idle.
        if (load || pv_q) begin
          val_d   = load ? value_a : pend_q;
          idx_d   = IDX_TOP;
          pv_d    = 1'b0;
          state_d = SCAN;
`ifdef SEG7_SCAN_LZBLANK_EN
          nz_d    = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset blanks every digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      val_q   <= '0;
      pend_q  <= '0;
      pv_q    <= 1'b0;
      seg_q   <= {NDIG{7'b1111111}};
`ifdef SEG7_SCAN_LZBLANK_EN
      nz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      seg_q   <= seg_d;
`ifdef SEG7_SCAN_LZBLANK_EN
      nz_q    <= nz_d;
`endif
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: scoreboard bench. Each scan that should happen pushes its
// expected final segment image; a monitor pops and compares on every done.
module tb_seg7_scan_ctrl;
  localparam int NDIG = 6;
  localparam int SW = 7 * NDIG;

  logic              clk = 1'b0;
  logic              rst;
  logic              load;
  logic [4*NDIG-1:0] value;
  logic              busy, done;
  logic [SW-1:0]     seg;

  int npass = 0;
  int ntot  = 0;
  logic [SW-1:0] expq[$];

  seg7_scan_ctrl #(.NDIG(NDIG)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .busy(busy), .done(done), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic logic [6:0] ref_dec(input logic [3:0] d);
    logic [6:0] t[16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[d];
  endfunction

  function automatic logic [SW-1:0] exp_seg(input logic [4*NDIG-1:0] v);
    logic [SW-1:0] r;
    logic nz;
    logic [3:0] d;
    r  = '1;
    nz = 1'b0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      d = v[4*i +: 4];
      r[7*i +: 7] = ref_dec(d);
`ifdef SEG7_SCAN_LZBLANK_EN
      if (d == 4'h0 && !nz && i != 0) r[7*i +: 7] = 7'b1111111;
`endif
      if (d != 4'h0) nz = 1'b1;
    end
    return r;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expected image.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (expq.size() == 0) chk("unexpected_done", 64'(seg), 64'h0);
      else chk("scan_result", 64'(seg), 64'(expq.pop_front()));
    end
  end

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; load = 1'b0; value = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_seg", 64'(seg), 64'(exp_seg('0) | {SW{1'b1}}));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    // Basic scan with timing of busy, first digit and done pulse.
    value = 24'h123456; load = 1'b1;
    expq.push_back(exp_seg(24'h123456));
    @(negedge clk); load = 1'b0;
    chk("busy_after_load", 64'(busy), 64'd1);
    @(negedge clk);
    chk("first_digit5", 64'(seg[41:35]), 64'(7'b1111001));
    chk("digit0_untouched", 64'(seg[6:0]), 64'(7'b1111111));
    repeat (4) @(negedge clk);
    chk("no_done_early", 64'(done), 64'd0);
    @(negedge clk);
    chk("done_on_time", 64'(done), 64'd1);
    chk("busy_in_done", 64'(busy), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    @(negedge clk);

    // Mid-scan load is queued and rescanned after the first completes.
    value = 24'hABCDEF; load = 1'b1;
    expq.push_back(exp_seg(24'hABCDEF));
    expq.push_back(exp_seg(24'h000009));
    @(negedge clk); load = 1'b0;
    @(negedge clk);
    value = 24'h000009; load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_done(20);
    @(negedge clk);
    chk("pending_rescan_busy", 64'(busy), 64'd1);
    wait_done(20);
    repeat (2) @(negedge clk);

    // Leading-zero patterns (blanked only when the macro is defined).
    foreach (value[i]) ;
    value = 24'h00A00F; load = 1'b1;
    expq.push_back(exp_seg(24'h00A00F));
    @(negedge clk); load = 1'b0;
    wait_done(20);
    repeat (2) @(negedge clk);
    value = 24'h000000; load = 1'b1;
    expq.push_back(exp_seg(24'h000000));
    @(negedge clk); load = 1'b0;
    wait_done(20);
    repeat (2) @(negedge clk);

    // Reset three cycles into a scan aborts it; no done afterwards.
    value = 24'h987654; load = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_seg", 64'(seg), 64'(exp_seg('0) | {SW{1'b1}}));
    chk("abort_busy", 64'(busy), 64'd0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("abort_no_done", 64'(cnt), 64'd0);
    value = 24'h0F00D0; load = 1'b1;
    expq.push_back(exp_seg(24'h0F00D0));
    @(negedge clk); load = 1'b0;
    wait_done(20);
    repeat (2) @(negedge clk);

    // Load held high: back-to-back scans, then one more from pending.
    value = 24'h5A5A5A; load = 1'b1;
    repeat (4) expq.push_back(exp_seg(24'h5A5A5A));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wait_done(20);
      if (k == 2) load = 1'b0;
      @(negedge clk);
      chk("b2b_busy", 64'(busy), 64'd1);
    end
    wait_done(20);
    repeat (3) @(negedge clk);
    chk("final_idle", 64'(busy), 64'd0);
    chk("queue_empty", 64'(expq.size()), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    chk("global_timeout", 64'd0, 64'd1);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
